// File: rtl/vgacon_term_pkg.sv
// Shared types and constants for the VGA text-console terminal controller.
package vgacon_term_pkg;

  localparam int         COLS_DEF  = 80;
  localparam int         ROWS_DEF  = 50;
  localparam logic [7:0] BLANK_DEF = 8'h20;
  localparam int         ADDR_W    = 13;

  typedef enum logic [1:0] {
    IDLE,
    CLR_LINE,
    CLR_ALL
  } state_t;

  localparam logic [6:0] CC_BS = 7'h08;
  localparam logic [6:0] CC_LF = 7'h0A;
  localparam logic [6:0] CC_FF = 7'h0C;
  localparam logic [6:0] CC_CR = 7'h0D;
  localparam logic [6:0] CC_SO = 7'h0E;
  localparam logic [6:0] CC_SI = 7'h0F;

  function automatic logic is_printable(input logic [6:0] code);
    return (code >= 7'h20) && (code <= 7'h7E);
  endfunction

endpackage

// File: rtl/vgacon_term_fill.sv
// Blank-fill sequencer: after a start pulse, emits `count` consecutive addresses
// from `base`, one per cycle. Shared by the line clear and the screen clear.
module vgacon_term_fill
  import vgacon_term_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W-1:0] count,
  output logic [ADDR_W-1:0] addr,
  output logic              wren,
  output logic              done
);

  logic              active_q, active_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] remain_q, remain_d;

  always_comb begin
    active_d = active_q;
    addr_d   = addr_q;
    remain_d = remain_q;
    if (start) begin
      active_d = (count != '0);
      addr_d   = base;
      remain_d = count;
    end else if (active_q) begin
      addr_d   = addr_q + ADDR_W'(1);
      remain_d = remain_q - ADDR_W'(1);
      if (remain_q == ADDR_W'(1)) active_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      active_q <= 1'b0;
      addr_q   <= '0;
      remain_q <= '0;
    end else begin
      active_q <= active_d;
      addr_q   <= addr_d;
      remain_q <= remain_d;
    end
  end

  assign addr = addr_q;
  assign wren = active_q;
  assign done = active_q && (remain_q == ADDR_W'(1));

endmodule

// File: rtl/vgacon_term.sv
// Terminal controller: decodes a byte stream into text-RAM writes, tracks the cursor
// and runs line/screen clears. Define VGACON_TERM_ATTR_EN to enable SO/SI colour attribute.
module vgacon_term
  import vgacon_term_pkg::*;
#(
  parameter int         COLS  = COLS_DEF,
  parameter int         ROWS  = ROWS_DEF,
  parameter logic [7:0] BLANK = BLANK_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        in_data,
  output logic [ADDR_W-1:0] tram_addr,
  output logic [7:0]        tram_wdata,
  output logic              tram_wren,
  output logic [6:0]        cursor_col,
  output logic [5:0]        cursor_row,
  output logic              busy
);

  localparam logic [ADDR_W-1:0] COLS_A       = ADDR_W'(COLS);
  localparam logic [ADDR_W-1:0] SCREEN_CELLS = ADDR_W'(ROWS * COLS);
  localparam logic [6:0]        LAST_COL     = 7'(COLS - 1);
  localparam logic [5:0]        LAST_ROW     = 6'(ROWS - 1);

  state_t            state_q, state_d;
  logic [6:0]        col_q, col_d;
  logic [5:0]        row_q, row_d;
  logic              kick_q, kick_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        wdata_q, wdata_d;
  logic              wren_q, wren_d;
  logic              busy_q, busy_d;
  logic              attr;

  logic              accept;
  logic [6:0]        code;
  logic [5:0]        row_next;
  logic [ADDR_W-1:0] cur_addr;
  logic [ADDR_W-1:0] next_line_base;
  logic              in_data_unused;

  logic              fill_start;
  logic [ADDR_W-1:0] fill_base, fill_count, fill_addr;
  logic              fill_wren, fill_done;

  assign in_ready       = (state_q == IDLE);
  assign accept         = in_valid && in_ready;
  assign code           = in_data[6:0];
  assign in_data_unused = in_data[7];
  assign row_next       = (row_q == LAST_ROW) ? 6'd0 : row_q + 6'd1;
  assign cur_addr       = ADDR_W'(row_q) * COLS_A + ADDR_W'(col_q);
  assign next_line_base = ADDR_W'(row_next) * COLS_A;

`ifdef VGACON_TERM_ATTR_EN
  logic attr_q, attr_d;
  assign attr = attr_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) attr_q <= 1'b0;
    else       attr_q <= attr_d;
  end
`else
  assign attr = 1'b0;
`endif

  // Byte decode, cursor update and the registered TRAM write mux.
  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    row_d      = row_q;
    kick_d     = 1'b0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wren_d     = 1'b0;
    fill_start = 1'b0;
    fill_base  = '0;
    fill_count = '0;
`ifdef VGACON_TERM_ATTR_EN
    attr_d     = attr_q;
`endif

    if (kick_q) begin
      fill_start = 1'b1;
      fill_count = SCREEN_CELLS;
    end else if (accept) begin
      if (is_printable(code)) begin
        wren_d  = 1'b1;
        addr_d  = cur_addr;
        wdata_d = {attr, code};
        if (col_q == LAST_COL) begin
          col_d      = 7'd0;
          row_d      = row_next;
          state_d    = CLR_LINE;
          fill_start = 1'b1;
          fill_base  = next_line_base;
          fill_count = COLS_A;
        end else begin
          col_d = col_q + 7'd1;
        end
      end else begin
        case (code)
          CC_CR: col_d = 7'd0;
          CC_LF: begin
            col_d      = 7'd0;
            row_d      = row_next;
            state_d    = CLR_LINE;
            fill_start = 1'b1;
            fill_base  = next_line_base;
            fill_count = COLS_A;
          end
          CC_BS: begin
            if (col_q != 7'd0) begin
              col_d   = col_q - 7'd1;
              wren_d  = 1'b1;
              addr_d  = cur_addr - ADDR_W'(1);
              wdata_d = BLANK;
            end
          end
          CC_FF: begin
            col_d      = 7'd0;
            row_d      = 6'd0;
            state_d    = CLR_ALL;
            fill_start = 1'b1;
            fill_count = SCREEN_CELLS;
          end
`ifdef VGACON_TERM_ATTR_EN
          CC_SO: attr_d = 1'b1;
          CC_SI: attr_d = 1'b0;
`endif
          default: ;
        endcase
      end
    end

    // Clear writes never carry the attribute bit.
    if (fill_wren) begin
      wren_d  = 1'b1;
      addr_d  = fill_addr;
      wdata_d = BLANK;
      if (fill_done) state_d = IDLE;
    end

    busy_d = (state_d != IDLE) || fill_wren;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= CLR_ALL;
      col_q   <= 7'd0;
      row_q   <= 6'd0;
      kick_q  <= 1'b1;
      addr_q  <= '0;
      wdata_q <= 8'd0;
      wren_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      kick_q  <= kick_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wren_q  <= wren_d;
      busy_q  <= busy_d;
    end
  end

  vgacon_term_fill u_fill (
    .clk   (clk),
    .reset (reset),
    .start (fill_start),
    .base  (fill_base),
    .count (fill_count),
    .addr  (fill_addr),
    .wren  (fill_wren),
    .done  (fill_done)
  );

  assign tram_addr  = addr_q;
  assign tram_wdata = wdata_q;
  assign tram_wren  = wren_q;
  assign cursor_col = col_q;
  assign cursor_row = row_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_vgacon_term.sv
// Scoreboard bench for vgacon_term: a behavioural terminal model queues expected
// TRAM writes as bytes are accepted; a negedge monitor pops and compares them.
module tb_vgacon_term;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic [12:0] tram_addr;
  logic [7:0]  tram_wdata;
  logic        tram_wren;
  logic [6:0]  cursor_col;
  logic [5:0]  cursor_row;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int wr_seen = 0;

  typedef struct packed {
    logic [12:0] addr;
    logic [7:0]  data;
    logic        clr;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  int   m_col = 0;
  int   m_row = 0;
  logic m_attr = 1'b0;

  vgacon_term dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .tram_addr  (tram_addr),
    .tram_wdata (tram_wdata),
    .tram_wren  (tram_wren),
    .cursor_col (cursor_col),
    .cursor_row (cursor_row),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic pushClear(input int base, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back('{addr: 13'(base + i), data: 8'h20, clr: 1'b1});
  endtask

  task automatic modelAdvance();
    m_row = (m_row == 49) ? 0 : m_row + 1;
    pushClear(m_row * 80, 80);
  endtask

  task automatic modelByte(input logic [7:0] b);
    logic [6:0] c;
    c = b[6:0];
    if (c >= 7'h20 && c <= 7'h7E) begin
      exp_q.push_back('{addr: 13'(m_row * 80 + m_col), data: {m_attr, c}, clr: 1'b0});
      if (m_col == 79) begin
        m_col = 0;
        modelAdvance();
      end else begin
        m_col++;
      end
    end else if (c == 7'h0D) begin
      m_col = 0;
    end else if (c == 7'h0A) begin
      m_col = 0;
      modelAdvance();
    end else if (c == 7'h08) begin
      if (m_col > 0) begin
        m_col--;
        exp_q.push_back('{addr: 13'(m_row * 80 + m_col), data: 8'h20, clr: 1'b0});
      end
    end else if (c == 7'h0C) begin
      m_col = 0;
      m_row = 0;
      pushClear(0, 4000);
    end
`ifdef VGACON_TERM_ATTR_EN
    else if (c == 7'h0E) m_attr = 1'b1;
    else if (c == 7'h0F) m_attr = 1'b0;
`endif
  endtask

  // Holds the byte until accepted; expected writes are queued at the handshake.
  task automatic applyStimulus(input logic [7:0] b);
    int waited = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && waited < 10000) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      checkOutput("ready_timeout", 16'(in_ready), 16'd1);
      in_valid = 1'b0;
      return;
    end
    modelByte(b);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic waitDrain(input string tag);
    int n = 0;
    while ((exp_q.size() != 0 || !in_ready) && n < 20000) begin
      @(negedge clk);
      n++;
    end
    checkOutput({tag, "_pending"}, 16'(exp_q.size()), 16'd0);
    checkOutput({tag, "_ready"}, 16'(in_ready), 16'd1);
  endtask

  always @(negedge clk) begin
    if (!reset && tram_wren) begin
      wr_seen++;
      checkOutput("write_expected", 16'(exp_q.size() != 0), 16'd1);
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        checkOutput("wr_addr", 16'(tram_addr), 16'(mon_e.addr));
        checkOutput("wr_data", 16'(tram_wdata), 16'(mon_e.data));
        if (mon_e.clr) checkOutput("busy_in_clear", 16'(busy), 16'd1);
      end
    end
  end

  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int cnt;
    int base;
    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;

    // Reset state and power-up clear
    repeat (3) @(negedge clk);
    checkOutput("rst_wren", 16'(tram_wren), 16'd0);
    checkOutput("rst_busy", 16'(busy), 16'd0);
    checkOutput("rst_col", 16'(cursor_col), 16'd0);
    checkOutput("rst_row", 16'(cursor_row), 16'd0);
    pushClear(0, 4000);
    reset = 1'b0;
    waitDrain("t1");
    checkOutput("t1_col", 16'(cursor_col), 16'd0);
    checkOutput("t1_row", 16'(cursor_row), 16'd0);
    checkOutput("t1_busy", 16'(busy), 16'd0);

    // Single printable: write visible the cycle after accept
    applyStimulus(8'h41);
    checkOutput("t2_wren", 16'(tram_wren), 16'd1);
    checkOutput("t2_addr", 16'(tram_addr), 16'd0);
    checkOutput("t2_data", 16'(tram_wdata), 16'h41);
    checkOutput("t2_col", 16'(cursor_col), 16'd1);
    checkOutput("t2_row", 16'(cursor_row), 16'd0);

    // Fill row 0 back to back; last column triggers a line advance
    for (int i = 0; i < 79; i++) applyStimulus(8'(8'h21 + (i % 90)));
    waitDrain("t3a");
    checkOutput("t3_col", 16'(cursor_col), 16'd0);
    checkOutput("t3_row", 16'(cursor_row), 16'd1);
    applyStimulus(8'h0A);
    waitDrain("t3b");
    checkOutput("t3_lf_row", 16'(cursor_row), 16'd2);

    // Ignored bytes, CR and bit 7 masking
    applyStimulus(8'h01);
    applyStimulus(8'h7F);
    applyStimulus(8'hC2);
    applyStimulus(8'h43);
    applyStimulus(8'h0D);
    waitDrain("cr");
    checkOutput("cr_col", 16'(cursor_col), 16'd0);

    // Backspace at col 3 of row 3, then at col 0
    applyStimulus(8'h0A);
    applyStimulus(8'h61);
    applyStimulus(8'h62);
    applyStimulus(8'h63);
    applyStimulus(8'h08);
    waitDrain("t5a");
    checkOutput("t5_col", 16'(cursor_col), 16'd2);
    checkOutput("t5_row", 16'(cursor_row), 16'd3);
    applyStimulus(8'h0D);
    applyStimulus(8'h08);
    waitDrain("t5b");
    checkOutput("t5_bs0_col", 16'(cursor_col), 16'd0);
    checkOutput("t5_bs0_row", 16'(cursor_row), 16'd3);

`ifdef VGACON_TERM_ATTR_EN
    applyStimulus(8'h0E);
    applyStimulus(8'h78);
    checkOutput("attr_data", 16'(tram_wdata), 16'hF8);
    applyStimulus(8'h0F);
    applyStimulus(8'h78);
    checkOutput("attr_off_data", 16'(tram_wdata), 16'h78);
    applyStimulus(8'h0D);
    waitDrain("attr");
`endif

    // Walk to the bottom row, then wrap to row 0
    for (int i = 0; i < 46; i++) applyStimulus(8'h0A);
    waitDrain("t4a");
    checkOutput("t4_row49", 16'(cursor_row), 16'd49);
    applyStimulus(8'h0A);
    checkOutput("t4_wrap_row", 16'(cursor_row), 16'd0);
    checkOutput("t4_wrap_col", 16'(cursor_col), 16'd0);
    cnt = 0;
    @(negedge clk);
    while (!in_ready && cnt < 200) begin
      cnt++;
      @(negedge clk);
    end
    checkOutput("t4_ready_low", 16'(cnt), 16'd80);
    waitDrain("t4b");

    // Form feed, then reset in the middle of the screen clear
    applyStimulus(8'h0C);
    base = wr_seen;
    cnt = 0;
    while ((wr_seen - base) < 1000 && cnt < 6000) begin
      @(negedge clk);
      #2;
      cnt++;
    end
    checkOutput("t6_reached", 16'(wr_seen - base), 16'd1000);
    reset = 1'b1;
    #1;
    checkOutput("t6_wren_drop", 16'(tram_wren), 16'd0);
    checkOutput("t6_busy_drop", 16'(busy), 16'd0);
    exp_q.delete();
    m_col  = 0;
    m_row  = 0;
    m_attr = 1'b0;
    repeat (2) @(negedge clk);
    pushClear(0, 4000);
    reset = 1'b0;
    waitDrain("t6");
    checkOutput("t6_col", 16'(cursor_col), 16'd0);
    checkOutput("t6_row", 16'(cursor_row), 16'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
